// File: rtl/mips_multicycle_control_pkg.sv
// Shared opcodes, ALUOp codes, FSM states and control word
// for the multicycle MIPS main controller.
package mips_multicycle_control_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  // *_mr fields only take effect in a MemReady cycle
  typedef struct packed {
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite_mr;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite_mr;
    logic       pcwrite;
    logic       branch;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_outputs.sv
// Combinational state -> control word decoder (Moore part).
// Unused state codes decode to an all-zero word.
module mips_multicycle_control_outputs
  import mips_multicycle_control_pkg::*;
(
  input  state_t i_state,
  output ctrl_t  o_c
);

  always_comb begin
    o_c = '0;
    unique case (i_state)
      S_FETCH: begin
        o_c.memread    = 1'b1;
        o_c.alusrcb    = SRCB_4;
        o_c.aluop      = ALUOP_ADD;
        o_c.pcsrc      = PC_ALU;
        o_c.irwrite_mr = 1'b1;
        o_c.pcwrite_mr = 1'b1;
      end
      S_DECODE: begin
        o_c.alusrcb = SRCB_IMMSH;
        o_c.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        o_c.alusrca = 1'b1;
        o_c.alusrcb = SRCB_IMM;
        o_c.aluop   = ALUOP_ADD;
      end
      S_MEMREAD: begin
        o_c.memread = 1'b1;
        o_c.iord    = 1'b1;
      end
      S_MEMWB: begin
        o_c.memtoreg = 1'b1;
        o_c.regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        o_c.memwrite = 1'b1;
        o_c.iord     = 1'b1;
      end
      S_EXECUTE: begin
        o_c.alusrca = 1'b1;
        o_c.alusrcb = SRCB_B;
        o_c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_c.regdst   = 1'b1;
        o_c.regwrite = 1'b1;
      end
      S_BRANCH: begin
        o_c.alusrca = 1'b1;
        o_c.alusrcb = SRCB_B;
        o_c.aluop   = ALUOP_SUB;
        o_c.pcsrc   = PC_ALUOUT;
        o_c.branch  = 1'b1;
      end
      S_ADDIWB: o_c.regwrite = 1'b1;
      S_JUMP: begin
        o_c.pcsrc   = PC_JUMP;
        o_c.pcwrite = 1'b1;
      end
      S_HALT: o_c.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: state register,
// next-state logic and MemReady/Zero gating of the control word.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       Illegal,
  output logic       Halted
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_c;
  logic   w_illegal;
  logic   w_is_mem;
  logic   w_is_r;
  logic   w_is_beq;
  logic   w_is_addi;
  logic   w_is_j;

  assign w_is_mem  = (Opcode == OP_LW) || (Opcode == OP_SW);
  assign w_is_r    = (Opcode == OP_R);
  assign w_is_beq  = (Opcode == OP_BEQ);
  assign w_is_addi = (Opcode == OP_ADDI);
  assign w_is_j    = (Opcode == OP_J);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    unique case (r_state)
      S_FETCH:  w_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          w_is_mem:  w_next = S_MEMADR;
          w_is_r:    w_next = S_EXECUTE;
          w_is_beq:  w_next = S_BRANCH;
          w_is_addi: w_next = S_ADDIEX;
          w_is_j:    w_next = S_JUMP;
          default: begin
            w_illegal = 1'b1;
            w_next    = ILLEGAL_HALT ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR:
        w_next = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: w_next = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  w_next = S_ALUWB;
      S_ADDIEX:   w_next = S_ADDIWB;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
  end

  mips_multicycle_control_outputs u_outputs (
    .i_state (r_state),
    .o_c     (w_c)
  );

  // Reset forces every output low asynchronously, even FETCH's MemRead
  assign IorD     = RESET_N & w_c.iord;
  assign MemRead  = RESET_N & w_c.memread;
  assign MemWrite = RESET_N & w_c.memwrite;
  assign IRWrite  = RESET_N & w_c.irwrite_mr & MemReady;
  assign RegDst   = RESET_N & w_c.regdst;
  assign MemtoReg = RESET_N & w_c.memtoreg;
  assign RegWrite = RESET_N & w_c.regwrite;
  assign ALUSrcA  = RESET_N & w_c.alusrca;
  assign ALUSrcB  = {2{RESET_N}} & w_c.alusrcb;
  assign ALUOp    = {2{RESET_N}} & w_c.aluop;
  assign PCSrc    = {2{RESET_N}} & w_c.pcsrc;
  assign PCEn     = RESET_N & ((w_c.pcwrite_mr & MemReady)
                  | w_c.pcwrite | (w_c.branch & Zero));
  assign Illegal  = RESET_N & w_illegal;
  assign Halted   = RESET_N & w_c.halted;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench: per-instruction phase model with random
// opcodes, MemReady stalls and Zero, plus directed corner cases.
module tb_mips_multicycle_control;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, J = 6'b000010;

  localparam int PH_FETCH = 0, PH_DEC = 1, PH_MADR = 2;
  localparam int PH_MRD = 3, PH_MWB = 4, PH_MWR = 5;
  localparam int PH_EX = 6, PH_AWB = 7, PH_BR = 8;
  localparam int PH_AIEX = 9, PH_AIWB = 10, PH_JMP = 11;
  localparam int PH_HALT = 12;

  typedef struct packed {
    logic       iord, memread, memwrite, irwrite;
    logic       regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       pcen, illegal, halted;
  } out_t;

  typedef struct {
    int ph;
    bit mr;
    bit z;
  } step_t;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [5:0]  Opcode = 6'd0;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b0;
  logic [16:0] o1, o0;

  int    tests = 0;
  int    fails = 0;
  int    irw_cnt;
  bit    cur_z;
  step_t q[$];

  always #5 CLK = ~CLK;

  mips_multicycle_control #(.ILLEGAL_HALT(1'b1)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .Opcode(Opcode),
    .Zero(Zero), .MemReady(MemReady),
    .IorD(o1[16]), .MemRead(o1[15]), .MemWrite(o1[14]),
    .IRWrite(o1[13]), .RegDst(o1[12]), .MemtoReg(o1[11]),
    .RegWrite(o1[10]), .ALUSrcA(o1[9]), .ALUSrcB(o1[8:7]),
    .ALUOp(o1[6:5]), .PCSrc(o1[4:3]), .PCEn(o1[2]),
    .Illegal(o1[1]), .Halted(o1[0])
  );

  mips_multicycle_control #(.ILLEGAL_HALT(1'b0)) dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .Opcode(Opcode),
    .Zero(Zero), .MemReady(MemReady),
    .IorD(o0[16]), .MemRead(o0[15]), .MemWrite(o0[14]),
    .IRWrite(o0[13]), .RegDst(o0[12]), .MemtoReg(o0[11]),
    .RegWrite(o0[10]), .ALUSrcA(o0[9]), .ALUSrcB(o0[8:7]),
    .ALUOp(o0[6:5]), .PCSrc(o0[4:3]), .PCEn(o0[2]),
    .Illegal(o0[1]), .Halted(o0[0])
  );

  function automatic bit legal(logic [5:0] op);
    return op inside {R, LW, SW, BEQ, ADDI, J};
  endfunction

  function automatic logic [16:0] exp_out(int ph, bit mr, bit z,
                                          bit ill);
    out_t e;
    e = '0;
    case (ph)
      PH_FETCH: begin
        e.memread = 1; e.alusrcb = 2'b01;
        e.irwrite = mr; e.pcen = mr;
      end
      PH_DEC:  begin e.alusrcb = 2'b11; e.illegal = ill; end
      PH_MADR, PH_AIEX: begin e.alusrca = 1; e.alusrcb = 2'b10; end
      PH_MRD:  begin e.memread = 1; e.iord = 1; end
      PH_MWB:  begin e.memtoreg = 1; e.regwrite = 1; end
      PH_MWR:  begin e.memwrite = 1; e.iord = 1; end
      PH_EX:   begin e.alusrca = 1; e.aluop = 2'b10; end
      PH_AWB:  begin e.regdst = 1; e.regwrite = 1; end
      PH_BR: begin
        e.alusrca = 1; e.aluop = 2'b01;
        e.pcsrc = 2'b01; e.pcen = z;
      end
      PH_AIWB: e.regwrite = 1;
      PH_JMP:  begin e.pcsrc = 2'b10; e.pcen = 1; end
      PH_HALT: e.halted = 1;
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic push(int ph);
    step_t s;
    s.ph = ph; s.mr = 1'($urandom); s.z = cur_z;
    q.push_back(s);
  endtask

  task automatic push_wait(int ph, int stalls);
    step_t s;
    s.ph = ph; s.z = cur_z;
    for (int i = 0; i < stalls; i++) begin
      s.mr = 1'b0; q.push_back(s);
    end
    s.mr = 1'b1; q.push_back(s);
  endtask

  task automatic build(logic [5:0] op, int fs, int ms);
    q.delete();
    push_wait(PH_FETCH, fs);
    push(PH_DEC);
    case (op)
      LW:   begin push(PH_MADR); push_wait(PH_MRD, ms); push(PH_MWB); end
      SW:   begin push(PH_MADR); push_wait(PH_MWR, ms); end
      R:    begin push(PH_EX); push(PH_AWB); end
      BEQ:  push(PH_BR);
      ADDI: begin push(PH_AIEX); push(PH_AIWB); end
      J:    push(PH_JMP);
      default: ;
    endcase
  endtask

  task automatic run_seq(string name);
    logic [16:0] e;
    foreach (q[i]) begin
      @(negedge CLK);
      MemReady = q[i].mr; Zero = q[i].z;
      #1;
      e = exp_out(q[i].ph, q[i].mr, q[i].z, !legal(Opcode));
      tests++;
      if (o1 !== e) begin
        fails++;
        $display("FAIL %s cyc%0d: got %h exp %h", name, i, o1, e);
      end
      if (o1[13]) irw_cnt++;
    end
  endtask

  task automatic check_fetch(string name, bit mr);
    logic [16:0] e;
    @(negedge CLK);
    MemReady = mr; #1;
    e = exp_out(PH_FETCH, mr, 0, 0);
    tests++;
    if (o1 !== e) begin
      fails++;
      $display("FAIL %s: got %h exp %h", name, o1, e);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 0; MemReady = 0;
    @(negedge CLK);
    RESET_N = 1;
  endtask

  task automatic test_reset();
    MemReady = 1; Opcode = LW;
    #3;
    tests++;
    if (o1 !== '0 || o0 !== '0) begin
      fails++;
      $display("FAIL reset_outs: got %h/%h exp 0", o1, o0);
    end
    @(negedge CLK);
    RESET_N = 1; #1;
    tests++;
    if (o1 !== exp_out(PH_FETCH, 1, 0, 0)) begin
      fails++;
      $display("FAIL reset_fetch: got %h", o1);
    end
    MemReady = 0;
    do_reset();
  endtask

  task automatic test_rtype();
    Opcode = R; cur_z = 0;
    build(R, 0, 0);
    run_seq("rtype");
    check_fetch("rtype_next", 0);
  endtask

  task automatic test_lw_stall();
    Opcode = LW; cur_z = 0; irw_cnt = 0;
    build(LW, 2, 3);
    run_seq("lw_stall");
    check_fetch("lw_cycle10", 0);
    tests++;
    if (irw_cnt != 1) begin
      fails++;
      $display("FAIL lw_irwrite: got %0d pulses exp 1", irw_cnt);
    end
  endtask

  task automatic test_beq();
    Opcode = BEQ;
    for (int zz = 0; zz < 2; zz++) begin
      cur_z = bit'(zz);
      build(BEQ, 0, 0);
      run_seq(zz ? "beq_z1" : "beq_z0");
      check_fetch("beq_next", 0);
    end
  endtask

  task automatic test_sw_jump();
    Opcode = SW; cur_z = 0;
    build(SW, 0, 4);
    run_seq("sw_stall");
    check_fetch("sw_next", 0);
    Opcode = J;
    build(J, 0, 0);
    run_seq("jump");
    check_fetch("jump_next", 0);
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    ops = '{R, LW, SW, BEQ, ADDI, J};
    for (int n = 0; n < 60; n++) begin
      Opcode = ops[$urandom_range(0, 5)];
      cur_z = 1'($urandom);
      build(Opcode, $urandom_range(0, 3), $urandom_range(0, 3));
      run_seq("random");
    end
    check_fetch("random_end", 0);
  endtask

  task automatic test_illegal();
    do_reset();
    Opcode = 6'b111111; cur_z = 0;
    build(Opcode, 0, 0);
    run_seq("illegal_dec");
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      MemReady = 0; Zero = 1'($urandom); #1;
      tests++;
      if (o1 !== exp_out(PH_HALT, 0, 0, 0)) begin
        fails++;
        $display("FAIL halt_hold: got %h", o1);
      end
      tests++;
      if (o0 !== exp_out(PH_FETCH, 0, 0, 0)) begin
        fails++;
        $display("FAIL illegal_nohalt: got %h", o0);
      end
    end
    do_reset();
    Opcode = R;
    check_fetch("halt_reset", 0);
  endtask

  task automatic test_reset_mid();
    Opcode = SW; cur_z = 0;
    build(SW, 0, 2);
    void'(q.pop_back());
    run_seq("mid_sw");
    #1 RESET_N = 0;
    #1;
    tests++;
    if (o1 !== '0) begin
      fails++;
      $display("FAIL reset_memwrite: got %h exp 0", o1);
    end
    @(negedge CLK);
    RESET_N = 1; MemReady = 0;
    check_fetch("mid_sw_after", 0);
    Opcode = R;
    build(R, 0, 0);
    run_seq("mid_r");
    #1 RESET_N = 0;
    #1;
    tests++;
    if (o1 !== '0) begin
      fails++;
      $display("FAIL reset_aluwb: got %h exp 0", o1);
    end
    @(negedge CLK);
    RESET_N = 1; MemReady = 0;
    check_fetch("mid_r_after", 0);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_beq();
    test_sw_jump();
    test_random();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
